// File: rtl/button_input_ctrl.sv
// Push-button conditioning: 2-flop sync and per-button debounce FSM, then sticky press flags and wrapping press counters.
// Registered status word for CPU readback; irq is a combinational OR of enabled pending flags, cleared by a masked strobe.
module button_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [1:0]  botones1,
  input  logic [1:0]  botones2,
  input  logic [3:0]  irq_en,
  input  logic        clr_valid,
  input  logic [3:0]  clr_mask,
  output logic [3:0]  level,
  output logic [3:0]  events,
  output logic [31:0] status,
  output logic        irq
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } db_state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       raw;
  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [3:0]       level_q;
  logic [3:0]       level_d;
  logic [3:0]       event_q;
  logic [3:0]       event_d;
  logic [3:0]       rise;
  logic [3:0]       clr_bits;
  db_state_e        state_q     [4];
  db_state_e        state_d     [4];
  logic [CNT_W-1:0] cnt_q       [4];
  logic [CNT_W-1:0] cnt_d       [4];
  logic [3:0]       press_cnt_q [4];
  logic [3:0]       press_cnt_d [4];

  assign raw = {botones2, botones1} ^ {4{ACTIVE_LOW}};

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i]     <= IDLE;
        cnt_q[i]       <= '0;
        press_cnt_q[i] <= '0;
      end
      level_q <= '0;
      event_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i]     <= state_d[i];
        cnt_q[i]       <= cnt_d[i];
        press_cnt_q[i] <= press_cnt_d[i];
      end
      level_q <= level_d;
      event_q <= event_d;
    end
  end

  // Entering COUNT already counts the first differing cycle, so the level flips
  // on the DEBOUNCE_CYCLES-th consecutive edge that sees s != level.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (sync2_q[i] != level_q[i]) begin
            state_d[i] = COUNT;
            cnt_d[i]   = CNT_ONE;
          end
        end
        COUNT: begin
          if (sync2_q[i] == level_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            level_d[i] = sync2_q[i];
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign rise     = level_d & ~level_q;
  assign clr_bits = {4{clr_valid}} & clr_mask;
  // A new press outranks a clear landing on the same edge.
  assign event_d  = (event_q & ~clr_bits) | rise;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      press_cnt_d[i] = press_cnt_q[i] + {3'b000, rise[i]};
    end
  end

  assign level  = level_q;
  assign events = event_q;
  assign irq    = |(event_q & irq_en);
  assign status = {8'h00, press_cnt_q[3], press_cnt_q[2], press_cnt_q[1], press_cnt_q[0],
                   event_q, level_q};

endmodule

// File: tb/tb_button_input_ctrl.sv
// Directed plus random bench for button_input_ctrl; reference model debounces via a sliding window of synchronized samples.
module tb_button_input_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  b1, b2, b1_b, b2_b;
  logic [3:0]  irq_en;
  logic        clr_valid;
  logic [3:0]  clr_mask;
  logic [3:0]  level_a, events_a, level_b, events_b;
  logic [31:0] status_a, status_b;
  logic        irq_a, irq_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0] m_s1, m_s, m_lvl, m_ev;
  logic [3:0] m_pc [4];
  logic [3:0] m_win [$];

  always #5 clk = ~clk;

  button_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(1'b0)) dut_a (
    .CLOCK_50(clk), .reset(rst_n), .botones1(b1), .botones2(b2),
    .irq_en(irq_en), .clr_valid(clr_valid), .clr_mask(clr_mask),
    .level(level_a), .events(events_a), .status(status_a), .irq(irq_a)
  );

  button_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(1'b1)) dut_b (
    .CLOCK_50(clk), .reset(rst_n), .botones1(b1_b), .botones2(b2_b),
    .irq_en(irq_en), .clr_valid(clr_valid), .clr_mask(clr_mask),
    .level(level_b), .events(events_b), .status(status_b), .irq(irq_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0;
    m_s  = '0;
    m_lvl = '0;
    m_ev = '0;
    for (int i = 0; i < 4; i++) m_pc[i] = '0;
    m_win.delete();
  endtask

  // A bit's level flips once the last D synchronized samples all disagree with it.
  task automatic model_edge();
    logic [3:0] rise;
    bit         all_diff;
    rise = '0;
    m_win.push_back(m_s);
    if (m_win.size() > D) void'(m_win.pop_front());
    for (int i = 0; i < 4; i++) begin
      all_diff = (m_win.size() == D);
      foreach (m_win[j]) if (m_win[j][i] == m_lvl[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_lvl[i] = ~m_lvl[i];
        if (m_lvl[i]) rise[i] = 1'b1;
      end
    end
    m_ev = (m_ev & ~(clr_valid ? clr_mask : 4'h0)) | rise;
    for (int i = 0; i < 4; i++) if (rise[i]) m_pc[i] = (m_pc[i] + 4'd1) % 16;
    m_s  = m_s1;
    m_s1 = {b2, b1};
  endtask

  function automatic logic [31:0] model_status();
    return {8'h00, m_pc[3], m_pc[2], m_pc[1], m_pc[0], m_ev, m_lvl};
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check("status", status_a, model_status());
    check("irq", {31'b0, irq_a}, {31'b0, |(m_ev & irq_en)});
  endtask

  initial begin
    logic [3:0] v;
    int idx;

    // Reset with raw activity on the buttons
    rst_n = 1'b0; b1 = 2'b00; b2 = 2'b00; b1_b = 2'b11; b2_b = 2'b11;
    irq_en = 4'h0; clr_valid = 1'b0; clr_mask = 4'h0;
    model_reset();
    #1;
    check("reset_status", status_a, 32'h0);
    check("reset_irq", {31'b0, irq_a}, 32'h0);
    for (int c = 0; c < 4; c++) begin
      b1 = 2'($urandom); b2 = 2'($urandom);
      cycle();
      check("reset_hold", status_a, 32'h0);
    end

    // Release and clean press of button 0
    rst_n = 1'b1; b1 = 2'b01; b2 = 2'b00;
    for (int c = 1; c <= 6; c++) begin
      cycle();
      if (c < 6) check("press_wait", status_a, 32'h0);
      else check("press_done", status_a, 32'h0000_0111);
    end
    check("lvlb_idle", {28'b0, level_b}, 32'h0);

    // Glitch on button 3 shorter than the debounce window
    b2 = 2'b10;
    for (int c = 0; c < 11; c++) begin
      if (c == 3) b2 = 2'b00;
      cycle();
      check("glitch", status_a, 32'h0000_0111);
    end

    // Release button 0, clear its event
    b1 = 2'b00;
    for (int c = 0; c < 8; c++) cycle();
    check("release", status_a, 32'h0000_0110);
    clr_valid = 1'b1; clr_mask = 4'b0001;
    cycle();
    clr_valid = 1'b0; clr_mask = 4'h0;
    check("clr_event", status_a, 32'h0000_0100);

    // Clear coinciding with the rise: set wins
    b1 = 2'b01;
    for (int c = 1; c <= 5; c++) cycle();
    clr_valid = 1'b1; clr_mask = 4'b0001;
    cycle();
    clr_valid = 1'b0; clr_mask = 4'h0;
    check("set_wins", status_a, 32'h0000_0211);
    cycle();
    clr_valid = 1'b1; clr_mask = 4'b0001;
    cycle();
    clr_valid = 1'b0; clr_mask = 4'h0;
    check("clr_keeps_cnt", status_a, 32'h0000_0201);
    b1 = 2'b00;
    for (int c = 0; c < 8; c++) cycle();
    check("release2", status_a, 32'h0000_0200);

    // Sixteen presses of button 3 with its interrupt enabled
    irq_en = 4'b1000;
    for (int p = 1; p <= 16; p++) begin
      b2 = 2'b10;
      for (int c = 0; c < 7; c++) cycle();
      if (p == 1) check("irq_first", {31'b0, irq_a}, 32'h1);
      if (p == 15) check("cnt3_15", {28'b0, status_a[23:20]}, 32'hF);
      b2 = 2'b00;
      for (int c = 0; c < 7; c++) cycle();
    end
    check("cnt3_wrap", status_a, 32'h0000_0280);
    check("irq_wrap", {31'b0, irq_a}, 32'h1);
    irq_en = 4'h0;
    #1;
    check("irq_gated", {31'b0, irq_a}, 32'h0);
    check("event_kept", {28'b0, events_a}, 32'h8);
    for (int c = 0; c < 3; c++) cycle();
    check("event_kept2", {28'b0, events_a}, 32'h8);

    // Active-low instance: pull botones1[1] low
    irq_en = 4'b0010;
    check("lvlb_pre", {28'b0, level_b}, 32'h0);
    b1_b = 2'b01;
    for (int c = 1; c <= 6; c++) begin
      cycle();
      if (c < 6) check("lvlb_wait", {28'b0, level_b}, 32'h0);
    end
    check("lvlb_set", {28'b0, level_b}, 32'h2);
    check("statusb", status_b, 32'h0000_1022);
    check("irqb", {31'b0, irq_b}, 32'h1);
    b1_b = 2'b11;
    irq_en = 4'h0;

    // Reset in the middle of a debounce on button 2
    b2 = 2'b01;
    for (int c = 0; c < 3; c++) cycle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst", status_a, 32'h0);
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cycle();
      if (c < 6) check("midrst_wait", status_a, 32'h0);
      else check("midrst_done", status_a, 32'h0001_0044);
    end

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        v = {b2, b1};
        idx = $urandom_range(0, 3);
        v[idx] = ~v[idx];
        {b2, b1} = v;
      end
      clr_valid = ($urandom_range(0, 3) == 0);
      clr_mask  = 4'($urandom);
      if ($urandom_range(0, 15) == 0) irq_en = 4'($urandom);
      if (c == 400) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rnd_rst", status_a, 32'h0);
      end
      if (c == 402) rst_n = 1'b1;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_input_ctrl.md
# button_input_ctrl

Input conditioning stage between the board push-buttons (`botones1`, `botones2`) and the processor's memory-mapped I/O in Proyecto2. It synchronizes and debounces the four raw button lines and exposes a 32-bit status word the CPU reads each frame. The word holds debounced levels, sticky press-event flags and per-button press counters. It also raises a level interrupt while any enabled event flag is pending; the CPU acknowledges events with a masked clear strobe.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: stable cycles required before a level change is accepted (10 ms at 50 MHz); minimum legal value 2.
- `CNT_W`, default 19: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `ACTIVE_LOW`, default 0: when 1, raw inputs are inverted before synchronization.

Ports:
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `botones1`  in  2  raw player-1 buttons, asynchronous; bit i maps to button index i.
- `botones2`  in  2  raw player-2 buttons, asynchronous; bit i maps to button index 2+i.
- `irq_en`  in  4  per-button interrupt enable.
- `clr_valid`  in  1  one-cycle clear strobe.
- `clr_mask`  in  4  event bits cleared when `clr_valid`=1.
- `level`  out  4  debounced button levels, 1 = pressed.
- `event`  out  4  sticky press flags.
- `status`  out  32  {8'b0, press_cnt[3], press_cnt[2], press_cnt[1], press_cnt[0], event[3:0], level[3:0]}; press_cnt[i] is 4 bits.
- `irq`  out  1  |(event & irq_en).

## Operation
- **Input vector.** raw[3:0] = {botones2, botones1}, XOR ACTIVE_LOW.
- **Synchronizer.** Each bit passes through a 2-flop synchronizer; its output is s[i].
- **Debounce FSM (per bit, two states).**
  - IDLE (s[i]==level[i]): cnt[i] held at 0.
  - COUNT (s[i]!=level[i]): cnt[i] increments each cycle.
  - When cnt[i]==DEBOUNCE_CYCLES-1 and s[i] still differs: level[i] <= s[i] and cnt[i] <= 0.
  - Any cycle with s[i]==level[i] returns the bit to IDLE with cnt[i]=0. A glitch shorter than DEBOUNCE_CYCLES is fully rejected.
- **Rise detect.** rise[i] = 1 on the edge where level[i] goes 0->1. Release (1->0) produces no event and no count.
- **Event flags.** event[i] <= (event[i] & ~(clr_valid & clr_mask[i])) | rise[i].
  - Set wins over a simultaneous clear.
  - Clearing an already-clear bit has no effect.
- **Press counters.** press_cnt[i] increments on rise[i] and wraps 15->0. Only reset clears them; clr does not.
- **Outputs.** `status`, `level`, `event` and `irq` are direct register or combinational views; nothing is multiplexed.

## Timing
- **Reset** (reset=0, asynchronous): sync flops, cnt, level, event and press_cnt go to 0. Therefore `level`=0, `event`=0, `status`=32'h0, `irq`=0 during reset and immediately after release.
- **Raw-to-level latency.** With raw stable from before edge k, s changes after edge k+1 and level changes after edge k+1+DEBOUNCE_CYCLES. That is DEBOUNCE_CYCLES+2 edges after the raw change is first sampled.
- **Event timing.** event[i], press_cnt[i] and level[i] update on the same edge; irq follows combinationally.
- **Clear.** Takes effect on the edge where clr_valid=1; event and irq drop after that edge.
- **irq_en.** Purely combinational gating; toggling it never alters event.
- **Reset mid-debounce.** Counters are discarded. After release, the button must again be stable DEBOUNCE_CYCLES+2 cycles.
- **Independence.** The four bits are fully independent; simultaneous presses on all buttons are all captured on the same edge.

## Test plan
- **Reset.** Drive reset=0 with raw activity, release -> status=32'h0, irq=0; no event until DEBOUNCE_CYCLES+2 stable cycles elapse.
- **Clean press** (DEBOUNCE_CYCLES=4). botones1=2'b01 sampled at edge 1 -> level[0]=1, event[0]=1, press_cnt[0]=1 after edge 6; status=32'h0000_0111.
- **Glitch rejection** (DEBOUNCE_CYCLES=4). botones2[1] high for 3 cycles then low -> level, event and status remain 0 throughout.
- **Clear vs set.** Pulse clr_valid with clr_mask=4'b0001 on the same edge rise[0] occurs -> event[0]=1. A later clear with mask 4'b0001 -> event[0]=0 and press_cnt[0] unchanged.
- **Wrap and irq.** 16 clean presses of button 3 with irq_en=4'b1000 -> press_cnt[3] goes 15->0 (status[23:20]=0) and irq=1 while event[3]=1. Setting irq_en=0 -> irq=0 with event[3] still 1.
- **ACTIVE_LOW=1.** Raw inputs idle at 1 -> level=0; driving botones1[1]=0 -> level[1]=1 after DEBOUNCE_CYCLES+2 edges.
